// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_t : FSM encoding (IDLE -> ACCESS -> RESP)
//   ALU_LW/ALU_SW : ALU control codes that select a memory operation; the
//                   ALU/decoder uses the same constants.
//   REG_IDX_W   : register-file index width.
//   is_mem_op() : true for the two control codes the LSU reacts to.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam logic [3:0] ALU_LW    = 4'b1001;
    localparam logic [3:0] ALU_SW    = 4'b1010;
    localparam int         REG_IDX_W = 5;

    function automatic logic is_mem_op(input logic [3:0] ctrl);
        return (ctrl == ALU_LW) || (ctrl == ALU_SW);
    endfunction

endpackage

// File: rtl/lsu_timeout_counter.sv
// Counts memory-access cycles that went by without an acknowledge.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   clear     : forces the count to zero (takes priority over enable)
//   enable    : advance the count by one this cycle
//   expired   : count has reached TIMEOUT_CYCLES-1, i.e. this is the last
//               cycle an acknowledge may still arrive
// TIMEOUT_CYCLES must be at least 1.
module lsu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Count only ever needs to represent 0 .. TIMEOUT_CYCLES-1; the owner
    // leaves ACCESS (and clears) on the cycle the terminal value is seen.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != CNT_LAST)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (count_reg == CNT_LAST);

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: performs word LW/SW with a single outstanding
// request/acknowledge transaction and returns load data to writeback.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   op_valid/op_ctrl/op_addr/op_wdata/op_rd : op from the ALU stage
//   busy                     : high while a transaction is in flight
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : data memory port
//   wb_valid/wb_rd/wb_data   : one-cycle load writeback
//   st_done                  : one-cycle store-retired pulse
//   err_misaligned           : one-cycle pulse, op address not word aligned
//   err_timeout              : one-cycle pulse, no ack within TIMEOUT_CYCLES
// Every output comes straight from a register.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [3:0]           op_ctrl,
    input  logic [ADDR_W-1:0]    op_addr,
    input  logic [DATA_W-1:0]    op_wdata,
    input  logic [REG_IDX_W-1:0] op_rd,
    output logic                 busy,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ack,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 st_done,
    output logic                 err_misaligned,
    output logic                 err_timeout
);

    lsu_state_t             state_reg, state_next;
    logic                   is_store_reg, is_store_next;
    logic [REG_IDX_W-1:0]   rd_reg, rd_next;
    logic                   busy_reg, busy_next;
    logic                   mem_req_reg, mem_req_next;
    logic                   mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]      mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]      mem_wdata_reg, mem_wdata_next;
    logic                   wb_valid_reg, wb_valid_next;
    logic [REG_IDX_W-1:0]   wb_rd_reg, wb_rd_next;
    logic [DATA_W-1:0]      wb_data_reg, wb_data_next;
    logic                   st_done_reg, st_done_next;
    logic                   err_mis_reg, err_mis_next;
    logic                   err_to_reg, err_to_next;

    logic                   tmo_clear;
    logic                   tmo_enable;
    logic                   tmo_expired;

    // The counter is held at zero outside ACCESS, so every transaction
    // starts counting from 0 on its first request cycle.
    assign tmo_clear  = (state_next != ACCESS);
    assign tmo_enable = (state_reg == ACCESS) && !mem_ack;

    lsu_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_next     = state_reg;
        is_store_next  = is_store_reg;
        rd_next        = rd_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        wb_rd_next     = wb_rd_reg;
        wb_data_next   = wb_data_reg;
        wb_valid_next  = 1'b0;
        st_done_next   = 1'b0;
        err_mis_next   = 1'b0;
        err_to_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (op_valid && is_mem_op(op_ctrl)) begin
                    if (op_addr[1:0] != 2'b00) begin
                        err_mis_next = 1'b1;
                    end else begin
                        state_next     = ACCESS;
                        is_store_next  = (op_ctrl == ALU_SW);
                        rd_next        = op_rd;
                        mem_addr_next  = op_addr;
                        mem_wdata_next = op_wdata;
                    end
                end
            end
            ACCESS: begin
                // Ack is checked first so an ack on the last allowed cycle
                // still completes the transaction.
                if (mem_ack) begin
                    state_next = RESP;
                    // Completion pulses are registered here so they appear
                    // during the RESP cycle.
                    wb_valid_next = !is_store_reg;
                    st_done_next  = is_store_reg;
                    if (!is_store_reg) begin
                        wb_data_next = mem_rdata;
                        wb_rd_next   = rd_reg;
                    end
                end else if (tmo_expired) begin
                    state_next  = IDLE;
                    err_to_next = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next    = (state_next != IDLE);
        mem_req_next = (state_next == ACCESS);
        mem_we_next  = (state_next == ACCESS) && is_store_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            is_store_reg  <= 1'b0;
            rd_reg        <= '0;
            busy_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            wb_valid_reg  <= 1'b0;
            wb_rd_reg     <= '0;
            wb_data_reg   <= '0;
            st_done_reg   <= 1'b0;
            err_mis_reg   <= 1'b0;
            err_to_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            is_store_reg  <= is_store_next;
            rd_reg        <= rd_next;
            busy_reg      <= busy_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            wb_valid_reg  <= wb_valid_next;
            wb_rd_reg     <= wb_rd_next;
            wb_data_reg   <= wb_data_next;
            st_done_reg   <= st_done_next;
            err_mis_reg   <= err_mis_next;
            err_to_reg    <= err_to_next;
        end
    end

    assign busy           = busy_reg;
    assign mem_req        = mem_req_reg;
    assign mem_we         = mem_we_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign wb_valid       = wb_valid_reg;
    assign wb_rd          = wb_rd_reg;
    assign wb_data        = wb_data_reg;
    assign st_done        = st_done_reg;
    assign err_misaligned = err_mis_reg;
    assign err_timeout    = err_to_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES = 4).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op_ctrl;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [4:0]  op_rd;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done;
    logic        err_misaligned;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES (TMO),
        .ADDR_W         (32),
        .DATA_W         (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .op_valid       (op_valid),
        .op_ctrl        (op_ctrl),
        .op_addr        (op_addr),
        .op_wdata       (op_wdata),
        .op_rd          (op_rd),
        .busy           (busy),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .st_done        (st_done),
        .err_misaligned (err_misaligned),
        .err_timeout    (err_timeout)
    );

    // ack_at: index of the request cycle (0 = first) in which mem_ack is
    // driven, -1 = never. exp_evt: cycle after acceptance of the first
    // completion/error pulse (0 = none). exp_idle: first cycle busy is low.
    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          ack_at;
        logic [31:0] rdata;
        int          exp_req;
        int          exp_wb;
        int          exp_st;
        int          exp_mis;
        int          exp_to;
        int          exp_evt;
        int          exp_idle;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int req_n = 0, wb_n = 0, st_n = 0, mis_n = 0, to_n = 0;
        int evt = 0, idle = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_ctrl  = v.ctrl;
        op_addr  = v.addr;
        op_wdata = v.wdata;
        op_rd    = v.rd;
        @(negedge clk);
        op_valid = 1'b0;
        op_ctrl  = 4'b0000;
        for (int c = 1; c <= 12; c++) begin
            if (mem_req) begin
                check("req_we", {31'd0, mem_we}, {31'd0, v.ctrl == ALU_SW});
                check("req_addr", mem_addr, v.addr);
                check("req_wdata", mem_wdata, v.wdata);
                req_n++;
            end
            if (wb_valid) wb_n++;
            if (st_done) st_n++;
            if (err_misaligned) mis_n++;
            if (err_timeout) to_n++;
            if ((wb_valid || st_done || err_misaligned || err_timeout) && evt == 0) evt = c;
            if (!busy && idle == 0) idle = c;
            mem_ack   = mem_req && ((req_n - 1) == v.ack_at);
            mem_rdata = v.rdata;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("req_cycles", req_n, v.exp_req);
        check("wb_count", wb_n, v.exp_wb);
        check("st_count", st_n, v.exp_st);
        check("mis_count", mis_n, v.exp_mis);
        check("tmo_count", to_n, v.exp_to);
        check("event_cycle", evt, v.exp_evt);
        check("idle_cycle", idle, v.exp_idle);
        if (v.exp_wb != 0) begin
            check("wb_data", wb_data, v.rdata);
            check("wb_rd", {27'd0, wb_rd}, {27'd0, v.rd});
        end
        $display("vec %0d ctrl=%b addr=0x%h req=%0d wb=%0d st=%0d mis=%0d tmo=%0d evt=%0d idle=%0d",
                 idx, v.ctrl, v.addr, req_n, wb_n, st_n, mis_n, to_n, evt, idle);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int reqs;
        int wbs;

        vecs[0] = '{ALU_LW, 32'h100, 32'h0,        5'd5,  0,  32'hDEADBEEF, 1, 1, 0, 0, 0, 2, 3};
        vecs[1] = '{ALU_SW, 32'h40,  32'h12345678, 5'd0,  3,  32'h0,        4, 0, 1, 0, 0, 5, 6};
        vecs[2] = '{ALU_LW, 32'h102, 32'h0,        5'd5,  -1, 32'h0,        0, 0, 0, 1, 0, 1, 1};
        vecs[3] = '{ALU_SW, 32'h80,  32'hAAAA5555, 5'd0,  -1, 32'h0,        4, 0, 0, 0, 1, 5, 5};
        vecs[4] = '{ALU_LW, 32'h200, 32'h0,        5'd7,  0,  32'hCAFEF00D, 1, 1, 0, 0, 0, 2, 3};
        vecs[5] = '{ALU_LW, 32'h10,  32'h0,        5'd0,  1,  32'h0BADF00D, 2, 1, 0, 0, 0, 3, 4};
        vecs[6] = '{4'b0000, 32'h104, 32'h0,       5'd3,  -1, 32'h0,        0, 0, 0, 0, 0, 0, 1};
        vecs[7] = '{ALU_SW, 32'h41,  32'h0,        5'd0,  -1, 32'h0,        0, 0, 0, 1, 0, 1, 1};
        vecs[8] = '{ALU_LW, 32'h20,  32'h0,        5'd12, 3,  32'h13572468, 4, 1, 0, 0, 0, 5, 6};

        rst       = 1'b1;
        op_valid  = 1'b0;
        op_ctrl   = 4'b0000;
        op_addr   = 32'h0;
        op_wdata  = 32'h0;
        op_rd     = 5'd0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_pulses", {29'd0, st_done, err_misaligned, err_timeout}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset asserted during the second request cycle.
        @(negedge clk);
        op_valid = 1'b1; op_ctrl = ALU_SW; op_addr = 32'h40; op_wdata = 32'h55;
        @(negedge clk);
        op_valid = 1'b0; op_ctrl = 4'b0000;
        check("rmid_req_c1", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        check("rmid_req_c2", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmid_req_after", {31'd0, mem_req}, 32'd0);
        check("rmid_busy_after", {31'd0, busy}, 32'd0);
        check("rmid_addr_after", mem_addr, 32'd0);
        pulses = 0;
        reqs = 0;
        for (int c = 0; c < 6; c++) begin
            mem_ack   = (c < 2);
            mem_rdata = 32'hFFFF0000;
            @(negedge clk);
            if (wb_valid || st_done || err_misaligned || err_timeout) pulses++;
            if (mem_req) reqs++;
        end
        mem_ack = 1'b0;
        check("rmid_stray_pulses", pulses, 32'd0);
        check("rmid_stray_req", reqs, 32'd0);
        $display("seq reset_mid_access pulses=%0d reqs=%0d", pulses, reqs);

        // Second LW presented while busy must be ignored.
        @(negedge clk);
        op_valid = 1'b1; op_ctrl = ALU_LW; op_addr = 32'h300; op_rd = 5'd9;
        @(negedge clk);
        op_addr = 32'h304; op_rd = 5'd10;
        wbs = 0;
        reqs = 0;
        for (int c = 1; c <= 10; c++) begin
            if (mem_req) begin
                check("busy_addr", mem_addr, 32'h300);
                reqs++;
            end
            if (wb_valid) wbs++;
            op_valid  = (c <= 3);
            mem_ack   = mem_req && (reqs == 3);
            mem_rdata = 32'h99887766;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        op_valid = 1'b0;
        check("busy_req_cycles", reqs, 32'd3);
        check("busy_wb_count", wbs, 32'd1);
        check("busy_wb_rd", {27'd0, wb_rd}, 32'd9);
        check("busy_wb_data", wb_data, 32'h99887766);
        $display("seq second_op_while_busy reqs=%0d wb=%0d rd=%0d", reqs, wbs, wb_rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes the ALU result as a byte address for LW/SW, plus the store data and destination register index.
- Runs a single outstanding request/acknowledge transaction with data memory and returns load data to writeback.
- Multi-cycle: holds the core via `busy` until the access retires, is rejected as misaligned, or times out.

Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles without mem_ack before the transaction is aborted. Must be ≥1.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  memory op presented this cycle
- op_ctrl  in  4  ALU control code; 4'b1001 = LW, 4'b1010 = SW, all others ignored
- op_addr  in  ADDR_W  ALU result (base + sign-extended imm)
- op_wdata  in  DATA_W  rs2 value for SW
- op_rd  in  5  destination register for LW
- busy  out  1  high when state != IDLE; core stalls
- mem_req  out  1  request to data memory
- mem_we  out  1  1 = write (SW), 0 = read (LW)
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completes request
- wb_valid  out  1  one-cycle pulse: load data ready
- wb_rd  out  5  destination register
- wb_data  out  DATA_W  loaded word
- st_done  out  1  one-cycle pulse: store retired
- err_misaligned  out  1  one-cycle pulse: op_addr[1:0] != 0
- err_timeout  out  1  one-cycle pulse: no ack within TIMEOUT_CYCLES

Behaviour:
- **Clock and reset:** one clock, clk. Reset rst is synchronous, active-high.
- **Reset values:** state = IDLE. busy, mem_req, mem_we, wb_valid, st_done, err_misaligned and err_timeout are 0. mem_addr, mem_wdata, wb_rd and wb_data are 0. Timeout counter is 0.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.
- **States:**
  - IDLE: accepts ops.
  - ACCESS: mem_req held high.
  - RESP: one cycle, emits the completion pulse.
- **IDLE, accepting an op:** an op is taken when op_valid=1 and op_ctrl is LW or SW.
  - op_addr[1:0] != 0: err_misaligned=1 in the next cycle, no memory access, remain IDLE.
  - Aligned: latch op_addr, op_wdata, op_rd and the load/store kind; go to ACCESS. Next cycle mem_req=1, mem_we = (SW).
- **IDLE, other ops:** op_valid with any other op_ctrl is ignored (no effect).
- **ACCESS:**
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until the cycle mem_ack=1.
  - The counter increments each ACCESS cycle with mem_ack=0.
  - mem_ack=1 (including the first ACCESS cycle): mem_req drops next cycle; go to RESP.
    - LW: wb_data <= mem_rdata and wb_rd <= latched rd.
  - Counter reaches TIMEOUT_CYCLES-1 with mem_ack=0: next cycle err_timeout=1, mem_req=0, state IDLE, no writeback.
  - mem_ack and the timeout on the same cycle: ack wins.
- **RESP:** LW gives wb_valid=1; SW gives st_done=1. Exactly one cycle, then IDLE. The counter clears.
- **Latency:** op accepted at edge 0 → mem_req high in cycle 1. Ack in cycle k → wb_valid/st_done in cycle k+1, busy low in cycle k+2. Minimum op-to-writeback is 2 cycles.
- **Ignored inputs:**
  - op_valid while busy is ignored; the core must hold the op.
  - mem_ack outside ACCESS is ignored.
- **Data handling:**
  - Write data is not modified; word access only (no byte/half access).
  - op_rd=0 loads still access memory and pulse wb_valid; the register file discards x0 writes.
- **Reset mid-transaction:** returns to IDLE on that edge. mem_req low, no wb_valid, st_done or error pulse. A later stray mem_ack is ignored.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum lsu_state_t {IDLE, ACCESS, RESP};
  - localparams ALU_LW = 4'b1001 and ALU_SW = 4'b1010, shared with the ALU/decoder;
  - localparam REG_IDX_W = 5.
- One natural sub-module: lsu_timeout_counter. It has clear/enable inputs, an `expired` output and a TIMEOUT_CYCLES parameter.

Test Plan:
- LW, immediate ack: op_ctrl=1001, op_addr=0x100, op_rd=5; mem_ack=1 with mem_rdata=0xDEADBEEF in the first req cycle → mem_req cycle 1, wb_valid cycle 2 with wb_rd=5 and wb_data=0xDEADBEEF, busy low cycle 3.
- SW, delayed ack: op_addr=0x40, op_wdata=0x12345678; ack after 3 wait cycles → mem_we=1 and addr/data stable for all 4 req cycles, st_done one pulse, wb_valid never asserted.
- Misaligned: LW with op_addr=0x102 → err_misaligned pulse next cycle, mem_req stays 0, busy stays 0.
- Timeout: SW with TIMEOUT_CYCLES=4 and no ack → mem_req high exactly 4 cycles, then err_timeout pulse. Then LW with ack=1 → wb_valid carries the new data.
- Reset mid-ACCESS: rst=1 in the 2nd req cycle → mem_req=0 next cycle. A later mem_ack produces no wb_valid or st_done.
- Non-memory op and busy: op_ctrl=0000 with op_valid=1 → no req. A second LW presented while busy → ignored until IDLE; exactly one wb_valid per accepted op.
